// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC source encodings
// used by the sequencer control and by anything that drives pc_source.
package pc_pkg;

  localparam int unsigned PC_SRC_W = 3;

  localparam logic [PC_SRC_W-1:0] PC_SEQ  = 3'b000;
  localparam logic [PC_SRC_W-1:0] PC_BR   = 3'b001;
  localparam logic [PC_SRC_W-1:0] PC_JMP  = 3'b010;
  localparam logic [PC_SRC_W-1:0] PC_ALU  = 3'b011;
  localparam logic [PC_SRC_W-1:0] PC_CALL = 3'b100;
  localparam logic [PC_SRC_W-1:0] PC_RET  = 3'b101;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push while full overwrites the oldest entry;
// entry storage is not reset since nothing reads it while the stack is empty.
module ras_stack #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_data,
  output logic [ADDR_W-1:0]          top,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // sp points at the next free slot; with power-of-two depth it wraps onto the oldest entry
  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[sp_q] = push_data;
      sp_d        = sp_q + PTR_W'(1);
      if (!full) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      sp_d  = sp_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top   = mem_q[sp_q - PTR_W'(1)];
  assign count = cnt_q;
  assign full  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, branch enable, CALL/RETURN via a
// return-address stack, and sticky stack overflow/underflow flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      ADDR_W     = 32,
  parameter int unsigned      STEP       = 1,
  parameter int unsigned      RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pc_write,
  input  logic                       pc_write_cond,
  input  logic                       zero,
  input  logic                       branch_ne,
  input  logic [PC_SRC_W-1:0]        pc_source,
  input  logic [ADDR_W-1:0]          jump_addr,
  input  logic [ADDR_W-1:0]          alu_out,
  input  logic [ADDR_W-1:0]          alu_result,
  input  logic                       err_clr,
  output logic [ADDR_W-1:0]          pc_out,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_full,
  output logic                       ras_empty,
  output logic                       ras_ovf,
  output logic                       ras_unf
);

  logic              pc_en_c;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc_c;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push, ras_pop;
  logic              ovf_evt, unf_evt;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  // Next-PC select; stack is only touched by CALL/RETURN with pc_en high
  always_comb begin
    pc_en_c  = pc_write | (pc_write_cond & (zero ^ branch_ne));
    pc_inc_c = pc_q + ADDR_W'(STEP);
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    if (pc_en_c) begin
      case (pc_source)
        PC_SEQ:  pc_d = pc_inc_c;
        PC_BR:   pc_d = alu_out;
        PC_JMP:  pc_d = jump_addr;
        PC_ALU:  pc_d = alu_result;
        PC_CALL: begin
          pc_d     = jump_addr;
          ras_push = 1'b1;
          ovf_evt  = ras_full;
        end
        PC_RET: begin
          if (ras_empty) begin
            unf_evt = 1'b1;
          end else begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
    // A new error in the clearing cycle takes priority over err_clr
    ovf_d = ovf_evt | (ovf_q & ~err_clr);
    unf_d = unf_evt | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc_c),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign pc_out  = pc_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a
// queue-based reference model; a second 8-bit instance covers PC wrap-around.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, pc_write_cond, zero, branch_ne, err_clr;
  logic [2:0]  pc_source;
  logic [31:0] jump_addr, alu_out, alu_result;
  logic [31:0] pc_out;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ras_ovf, ras_unf;
  logic [7:0]  pc_out8;
  logic [2:0]  ras_count8;
  logic        ras_full8, ras_empty8, ras_ovf8, ras_unf8;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  logic        m_ovf, m_unf;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(32), .STEP(1), .RAS_DEPTH(4), .RESET_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .zero(zero), .branch_ne(branch_ne), .pc_source(pc_source),
    .jump_addr(jump_addr), .alu_out(alu_out), .alu_result(alu_result),
    .err_clr(err_clr), .pc_out(pc_out), .ras_count(ras_count),
    .ras_full(ras_full), .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  pc_sequencer #(.ADDR_W(8), .STEP(1), .RAS_DEPTH(4), .RESET_ADDR(8'h0)) dut8 (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .zero(zero), .branch_ne(branch_ne), .pc_source(pc_source),
    .jump_addr(jump_addr[7:0]), .alu_out(alu_out[7:0]), .alu_result(alu_result[7:0]),
    .err_clr(err_clr), .pc_out(pc_out8), .ras_count(ras_count8),
    .ras_full(ras_full8), .ras_empty(ras_empty8), .ras_ovf(ras_ovf8), .ras_unf(ras_unf8)
  );

  task automatic idle();
    pc_write = 0; pc_write_cond = 0; zero = 0; branch_ne = 0; err_clr = 0;
    pc_source = PC_SEQ; jump_addr = '0; alu_out = '0; alu_result = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    #2 rst = 0;
  endtask

  task automatic ctrl(input logic [2:0] src, input logic [31:0] jaddr);
    pc_write = 1; pc_source = src; jump_addr = jaddr;
    step();
  endtask

  // Architectural model: PC as a number, stack as a bounded list of return addresses
  function automatic void model_step();
    logic en;
    logic [31:0] nxt;
    logic ovf_e, unf_e;
    en = pc_write | (pc_write_cond & (zero != branch_ne));
    nxt = m_pc; ovf_e = 0; unf_e = 0;
    if (en) begin
      case (pc_source)
        3'd0: nxt = m_pc + 32'd1;
        3'd1: nxt = alu_out;
        3'd2: nxt = jump_addr;
        3'd3: nxt = alu_result;
        3'd4: begin
          nxt = jump_addr;
          if (m_stk.size() == 4) begin
            ovf_e = 1;
            void'(m_stk.pop_front());
          end
          m_stk.push_back(m_pc + 32'd1);
        end
        3'd5: begin
          if (m_stk.size() == 0) unf_e = 1;
          else nxt = m_stk.pop_back();
        end
        default: nxt = m_pc;
      endcase
    end
    if (err_clr) begin m_ovf = 0; m_unf = 0; end
    if (ovf_e) m_ovf = 1;
    if (unf_e) m_unf = 1;
    m_pc = nxt;
  endfunction

  task automatic test_reset();
    idle();
    rst = 1;
    #2;
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h required=%h", pc_out, 32'h0); end
    checks++; if (ras_count !== 3'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin failures++; $display("FAIL reset_stack count=%0d empty=%b full=%b required=0/1/0", ras_count, ras_empty, ras_full); end
    checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin failures++; $display("FAIL reset_flags ovf=%b unf=%b required=0/0", ras_ovf, ras_unf); end
    checks++; if (pc_out8 !== 8'h0) begin failures++; $display("FAIL reset_pc8 actual=%h required=00", pc_out8); end
    step();
    #2 rst = 0;
  endtask

  task automatic test_seq();
    for (int i = 1; i <= 3; i++) begin
      ctrl(PC_SEQ, 32'h0);
      checks++; if (pc_out !== 32'(i)) begin failures++; $display("FAIL seq_step%0d actual=%h required=%h", i, pc_out, 32'(i)); end
    end
    idle();
  endtask

  task automatic test_branch();
    idle();
    pc_write_cond = 1; pc_source = PC_BR; alu_out = 32'h40;
    zero = 1; branch_ne = 1;
    step();
    checks++; if (pc_out !== 32'h3) begin failures++; $display("FAIL branch_ne_hold actual=%h required=%h", pc_out, 32'h3); end
    zero = 1; branch_ne = 0;
    step();
    checks++; if (pc_out !== 32'h40) begin failures++; $display("FAIL branch_eq_taken actual=%h required=%h", pc_out, 32'h40); end
    zero = 0; branch_ne = 1; alu_out = 32'h88;
    step();
    checks++; if (pc_out !== 32'h88) begin failures++; $display("FAIL branch_ne_taken actual=%h required=%h", pc_out, 32'h88); end
    zero = 0; branch_ne = 0; alu_out = 32'h99;
    step();
    checks++; if (pc_out !== 32'h88) begin failures++; $display("FAIL branch_eq_hold actual=%h required=%h", pc_out, 32'h88); end
    idle();
  endtask

  task automatic test_nested_call();
    do_reset();
    ctrl(PC_JMP, 32'h10);
    ctrl(PC_CALL, 32'h100);
    checks++; if (pc_out !== 32'h100 || ras_count !== 3'd1) begin failures++; $display("FAIL call1 pc=%h count=%0d required=100/1", pc_out, ras_count); end
    ctrl(PC_CALL, 32'h200);
    checks++; if (pc_out !== 32'h200 || ras_count !== 3'd2) begin failures++; $display("FAIL call2 pc=%h count=%0d required=200/2", pc_out, ras_count); end
    ctrl(PC_RET, 32'h0);
    checks++; if (pc_out !== 32'h101 || ras_count !== 3'd1) begin failures++; $display("FAIL ret1 pc=%h count=%0d required=101/1", pc_out, ras_count); end
    ctrl(PC_RET, 32'h0);
    checks++; if (pc_out !== 32'h11 || ras_empty !== 1'b1) begin failures++; $display("FAIL ret2 pc=%h empty=%b required=11/1", pc_out, ras_empty); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ctrl(PC_JMP, 32'h50);
    ctrl(PC_CALL, 32'h700);
    ctrl(PC_RET, 32'h0);
    checks++; if (pc_out !== 32'h51 || ras_count !== 3'd0) begin failures++; $display("FAIL b2b_ret pc=%h count=%0d required=51/0", pc_out, ras_count); end
    idle();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_ret [4];
    do_reset();
    for (int i = 1; i <= 5; i++) ctrl(PC_CALL, 32'(i) * 32'h100);
    checks++; if (ras_ovf !== 1'b1 || ras_count !== 3'd4 || ras_full !== 1'b1) begin failures++; $display("FAIL ovf_set ovf=%b count=%0d full=%b required=1/4/1", ras_ovf, ras_count, ras_full); end
    checks++; if (pc_out !== 32'h500) begin failures++; $display("FAIL ovf_jump actual=%h required=%h", pc_out, 32'h500); end
    exp_ret[0] = 32'h401; exp_ret[1] = 32'h301; exp_ret[2] = 32'h201; exp_ret[3] = 32'h101;
    for (int i = 0; i < 4; i++) begin
      ctrl(PC_RET, 32'h0);
      checks++; if (pc_out !== exp_ret[i]) begin failures++; $display("FAIL ovf_ret%0d actual=%h required=%h", i, pc_out, exp_ret[i]); end
    end
    ctrl(PC_RET, 32'h0);
    checks++; if (pc_out !== 32'h101 || ras_unf !== 1'b1 || ras_count !== 3'd0) begin failures++; $display("FAIL unf pc=%h unf=%b count=%0d required=101/1/0", pc_out, ras_unf, ras_count); end
    idle();
    err_clr = 1;
    step();
    checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin failures++; $display("FAIL err_clr ovf=%b unf=%b required=0/0", ras_ovf, ras_unf); end
    pc_write = 1; pc_source = PC_RET;
    step();
    checks++; if (ras_unf !== 1'b1) begin failures++; $display("FAIL err_clr_priority unf=%b required=1", ras_unf); end
    idle();
  endtask

  task automatic test_wrap();
    do_reset();
    ctrl(PC_JMP, 32'hFF);
    checks++; if (pc_out8 !== 8'hFF) begin failures++; $display("FAIL wrap_setup actual=%h required=ff", pc_out8); end
    ctrl(PC_SEQ, 32'h0);
    checks++; if (pc_out8 !== 8'h00) begin failures++; $display("FAIL wrap8 actual=%h required=00", pc_out8); end
    checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL wrap32 actual=%h required=%h", pc_out, 32'h100); end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    ctrl(PC_CALL, 32'h300);
    pc_write = 1; pc_source = PC_CALL; jump_addr = 32'h400;
    #3 rst = 1;
    #1;
    checks++; if (pc_out !== 32'h0 || ras_count !== 3'd0) begin failures++; $display("FAIL async_rst pc=%h count=%0d required=0/0", pc_out, ras_count); end
    step();
    #2 rst = 0;
    idle();
    step();
    checks++; if (pc_out !== 32'h0 || ras_count !== 3'd0 || ras_ovf !== 1'b0) begin failures++; $display("FAIL async_rst_release pc=%h count=%0d ovf=%b required=0/0/0", pc_out, ras_count, ras_ovf); end
  endtask

  task automatic test_random();
    do_reset();
    m_pc = 32'h0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    for (int n = 0; n < 400; n++) begin
      pc_write      = ($urandom_range(0, 1) == 1);
      pc_write_cond = ($urandom_range(0, 1) == 1);
      zero          = ($urandom_range(0, 1) == 1);
      branch_ne     = ($urandom_range(0, 1) == 1);
      err_clr       = ($urandom_range(0, 9) == 0);
      pc_source     = 3'($urandom_range(0, 7));
      jump_addr     = $urandom;
      alu_out       = $urandom;
      alu_result    = $urandom;
      model_step();
      step();
      checks++; if (pc_out !== m_pc) begin failures++; $display("FAIL rand_pc cyc=%0d actual=%h required=%h", n, pc_out, m_pc); end
      checks++; if (ras_count !== 3'(m_stk.size())) begin failures++; $display("FAIL rand_count cyc=%0d actual=%0d required=%0d", n, ras_count, m_stk.size()); end
      checks++; if (ras_ovf !== m_ovf || ras_unf !== m_unf) begin failures++; $display("FAIL rand_flags cyc=%0d ovf=%b unf=%b required=%b/%b", n, ras_ovf, ras_unf, m_ovf, m_unf); end
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_nested_call();
    test_back_to_back();
    test_overflow();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
